// File: rtl/writeback_unit_pkg.sv
// Shared types for the writeback unit: FSM state encoding, the result record
// carried from the ALU/memory pipes to the register-file write port, and the
// architectural register count.
package writeback_unit_pkg;

  localparam int NUM_REGS            = 32;
  localparam int WB_REGISTER_WIDTH   = 64;
  localparam int WB_REGISTERNO_WIDTH = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  // One pending register write: destination register number and its data.
  typedef struct packed {
    logic [WB_REGISTERNO_WIDTH-1:0] rd;
    logic [WB_REGISTER_WIDTH-1:0]   value;
  } wb_result_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Small synchronous FIFO of wb_result_t used to buffer ALU results while the
// memory pipe owns the register-file write port. The head entry is visible on
// pop_data whenever empty is low. Push when full and pop when empty are ignored.
module wb_result_fifo
  import writeback_unit_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  wb_result_t push_data,
  input  logic       pop,
  output wb_result_t pop_data,
  output logic       full,
  output logic       empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wb_result_t    mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when the indices match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset empties the buffer and drops any stored results.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/writeback_unit.sv
// Writeback unit: merges the ALU and memory result streams into a single
// register-file write per cycle, tracks which registers have writes in flight
// (busy_mask) so issue can stall on RAW hazards, and sequences end-of-program
// (drain all writes, pulse display_regs once, then report halted).
//
// Handshake: a transfer happens on the clock edge where valid && ready are both
// high; the producer holds valid, rd and value stable until then, and ready is
// computed only from internal state, never from valid.
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int REGISTER_WIDTH   = WB_REGISTER_WIDTH,
  parameter int REGISTERNO_WIDTH = WB_REGISTERNO_WIDTH,
  parameter int ALU_FIFO_DEPTH   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_valid,
  output logic                        alu_ready,
  input  logic [REGISTERNO_WIDTH-1:0] alu_rd,
  input  logic [REGISTER_WIDTH-1:0]   alu_value,
  input  logic                        mem_valid,
  output logic                        mem_ready,
  input  logic [REGISTERNO_WIDTH-1:0] mem_rd,
  input  logic [REGISTER_WIDTH-1:0]   mem_value,
  input  logic                        issue_valid,
  input  logic [REGISTERNO_WIDTH-1:0] issue_rd,
  output logic [NUM_REGS-1:0]         busy_mask,
  input  logic                        halt_req,
  output logic                        wr_enable,
  output logic [REGISTERNO_WIDTH-1:0] rd_regno,
  output logic [REGISTER_WIDTH-1:0]   rd_value,
  output logic                        display_regs,
  output logic                        halted,
  output logic [1:0]                  dbg_state
);

  wb_state_t     state;
  wb_state_t     next_state;

  wb_result_t    alu_result;
  wb_result_t    mem_result;
  wb_result_t    fifo_head;
  wb_result_t    sel_result;
  logic          sel_valid;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic          mem_accept;
  logic          port_active;
  logic          drained;
  logic [NUM_REGS-1:0] busy_next;

  assign dbg_state = state;

  assign alu_result.rd    = alu_rd;
  assign alu_result.value = alu_value;
  assign mem_result.rd    = mem_rd;
  assign mem_result.value = mem_value;

  // The write port only moves results while running or draining.
  assign port_active = (state == RUN) || (state == DRAIN);
  assign mem_accept  = mem_valid && mem_ready;
  assign fifo_push   = alu_valid && alu_ready;
  // Memory results own the port; the buffered ALU head waits while one is offered.
  assign fifo_pop    = port_active && !fifo_empty && !mem_valid;

  assign drained = fifo_empty && !mem_valid && !wr_enable && (busy_mask == '0);

  wb_result_fifo #(
    .DEPTH(ALU_FIFO_DEPTH)
  ) u_alu_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_push),
    .push_data(alu_result),
    .pop      (fifo_pop),
    .pop_data (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Pick this cycle's writer: memory first, otherwise the ALU buffer head.
  always_comb begin
    sel_valid  = 1'b0;
    sel_result = mem_result;
    if (mem_accept) begin
      sel_valid  = 1'b1;
      sel_result = mem_result;
    end else if (fifo_pop) begin
      sel_valid  = 1'b1;
      sel_result = fifo_head;
    end
  end

  // Registered write port; results targeting x0 are consumed without a write.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_enable <= 1'b0;
      rd_regno  <= '0;
      rd_value  <= '0;
    end else begin
      wr_enable <= sel_valid && (sel_result.rd != '0);
      if (sel_valid && (sel_result.rd != '0)) begin
        rd_regno <= sel_result.rd;
        rd_value <= sel_result.value;
      end
    end
  end

  // Busy scoreboard: the committing write clears its bit on the same edge the
  // register file captures it; a new issue to the same register wins.
  always_comb begin
    busy_next = busy_mask;
    if (wr_enable) busy_next[rd_regno] = 1'b0;
    if (issue_valid && (issue_rd != '0)) busy_next[issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (reset) busy_mask <= '0;
    else       busy_mask <= busy_next;
  end

  // FSM state register; leaving RUN is itself the latch for a halt pulse.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= next_state;
  end

  // FSM next state and handshake/status outputs.
  always_comb begin
    next_state   = state;
    alu_ready    = 1'b0;
    mem_ready    = 1'b0;
    display_regs = 1'b0;
    halted       = 1'b0;
    case (state)
      RUN: begin
        alu_ready = !fifo_full;
        mem_ready = 1'b1;
        if (halt_req) next_state = DRAIN;
      end
      DRAIN: begin
        mem_ready = 1'b1;
        if (drained) next_state = DUMP;
      end
      DUMP: begin
        display_regs = 1'b1;
        next_state   = DONE;
      end
      DONE: begin
        halted = 1'b1;
      end
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit. Each scenario pushes its hand-computed
// write sequence into exp_q; a monitor pops and compares on every wr_enable.
module tb_writeback_unit;

  localparam int RW  = 64;
  localparam int RNW = 5;
  localparam int EW  = RW + RNW;

  logic            clk;
  logic            reset;
  logic            alu_valid;
  logic            alu_ready;
  logic [RNW-1:0]  alu_rd;
  logic [RW-1:0]   alu_value;
  logic            mem_valid;
  logic            mem_ready;
  logic [RNW-1:0]  mem_rd;
  logic [RW-1:0]   mem_value;
  logic            issue_valid;
  logic [RNW-1:0]  issue_rd;
  logic [31:0]     busy_mask;
  logic            halt_req;
  logic            wr_enable;
  logic [RNW-1:0]  rd_regno;
  logic [RW-1:0]   rd_value;
  logic            display_regs;
  logic            halted;
  logic [1:0]      dbg_state;

  logic [EW-1:0]   exp_q[$];
  int              n_checks;
  int              n_pass;
  logic [31:0]     busy_snap;

  writeback_unit #(
    .REGISTER_WIDTH  (RW),
    .REGISTERNO_WIDTH(RNW),
    .ALU_FIFO_DEPTH  (2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .alu_rd      (alu_rd),
    .alu_value   (alu_value),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd      (mem_rd),
    .mem_value   (mem_value),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .busy_mask   (busy_mask),
    .halt_req    (halt_req),
    .wr_enable   (wr_enable),
    .rd_regno    (rd_regno),
    .rd_value    (rd_value),
    .display_regs(display_regs),
    .halted      (halted),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [RNW-1:0] rd, input logic [RW-1:0] value);
    exp_q.push_back({rd, value});
  endtask

  task automatic drive_mem(input logic v, input logic [RNW-1:0] rd, input logic [RW-1:0] value);
    mem_valid = v;
    mem_rd    = rd;
    mem_value = value;
  endtask

  task automatic drive_alu(input logic v, input logic [RNW-1:0] rd, input logic [RW-1:0] value);
    alu_valid = v;
    alu_rd    = rd;
    alu_value = value;
  endtask

  // Monitor: every committed write must be the next expected one.
  always @(negedge clk) begin
    if (!reset && wr_enable) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {rd_regno, rd_value}, '0);
      end else begin
        check("write_data", {rd_regno, rd_value}, exp_q.pop_front());
      end
    end
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset = 1'b1;
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    issue_valid = 1'b0;
    issue_rd    = '0;
    halt_req    = 1'b0;
    repeat (3) tick();

    // Reset state.
    check("rst_wr_enable", EW'(wr_enable), EW'(0));
    check("rst_regno_value", {rd_regno, rd_value}, '0);
    check("rst_busy", EW'(busy_mask), EW'(0));
    check("rst_ready", EW'({alu_ready, mem_ready}), EW'(2'b11));
    check("rst_status", EW'({display_regs, halted}), EW'(2'b00));
    reset = 1'b0;
    tick();

    // 1: memory write latency and busy clear timing.
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    issue_valid = 1'b0;
    check("t1_busy5_set", EW'(busy_mask[5]), EW'(1));
    push_exp(5'd5, 64'h1234);
    drive_mem(1'b1, 5'd5, 64'h1234);
    tick();
    drive_mem(1'b0, '0, '0);
    check("t1_wr_next_cycle", EW'({wr_enable, rd_regno}), EW'({1'b1, 5'd5}));
    check("t1_busy5_during_wr", EW'(busy_mask[5]), EW'(1));
    tick();
    check("t1_wr_done", EW'(wr_enable), EW'(0));
    check("t1_busy5_cleared", EW'(busy_mask[5]), EW'(0));

    // 2: simultaneous sources, memory first.
    push_exp(5'd4, 64'h44);
    push_exp(5'd3, 64'h33);
    drive_alu(1'b1, 5'd3, 64'h33);
    drive_mem(1'b1, 5'd4, 64'h44);
    tick();
    drive_alu(1'b0, '0, '0);
    drive_mem(1'b0, '0, '0);
    check("t2_first_reg4", EW'({wr_enable, rd_regno}), EW'({1'b1, 5'd4}));
    check("t2_alu_ready", EW'(alu_ready), EW'(1));
    tick();
    check("t2_second_reg3", EW'({wr_enable, rd_regno}), EW'({1'b1, 5'd3}));
    tick();
    check("t2_idle", EW'(wr_enable), EW'(0));

    // 3: memory held 4 cycles fills the ALU buffer, then it drains.
    push_exp(5'd10, 64'hA0); push_exp(5'd11, 64'hA1);
    push_exp(5'd12, 64'hA2); push_exp(5'd13, 64'hA3);
    push_exp(5'd20, 64'hB0); push_exp(5'd21, 64'hB1); push_exp(5'd22, 64'hB2);
    check("t3_ready_start", EW'(alu_ready), EW'(1));
    drive_mem(1'b1, 5'd10, 64'hA0);
    drive_alu(1'b1, 5'd20, 64'hB0);
    tick();
    check("t3_ready_one_entry", EW'(alu_ready), EW'(1));
    drive_mem(1'b1, 5'd11, 64'hA1);
    drive_alu(1'b1, 5'd21, 64'hB1);
    tick();
    check("t3_ready_full_c2", EW'(alu_ready), EW'(0));
    drive_mem(1'b1, 5'd12, 64'hA2);
    drive_alu(1'b1, 5'd22, 64'hB2);
    tick();
    check("t3_ready_full_c3", EW'(alu_ready), EW'(0));
    drive_mem(1'b1, 5'd13, 64'hA3);
    tick();
    check("t3_ready_full_c4", EW'(alu_ready), EW'(0));
    drive_mem(1'b0, '0, '0);
    tick();
    check("t3_ready_after_pop", EW'(alu_ready), EW'(1));
    tick();
    drive_alu(1'b0, '0, '0);
    tick();
    tick();
    check("t3_all_written", EW'(exp_q.size()), EW'(0));

    // 4: result for x0 is swallowed.
    busy_snap = busy_mask;
    drive_alu(1'b1, 5'd0, 64'hFF);
    tick();
    drive_alu(1'b0, '0, '0);
    repeat (3) begin
      tick();
      check("t4_no_wr_x0", EW'(wr_enable), EW'(0));
    end
    check("t4_busy_unchanged", EW'(busy_mask), EW'(busy_snap));

    // 5: issue to a register on the edge its write commits keeps it busy.
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    push_exp(5'd7, 64'h77);
    drive_mem(1'b1, 5'd7, 64'h77);
    tick();
    drive_mem(1'b0, '0, '0);
    check("t5_wr_reg7", EW'({wr_enable, rd_regno}), EW'({1'b1, 5'd7}));
    issue_valid = 1'b1; issue_rd = 5'd7;
    tick();
    issue_valid = 1'b0;
    check("t5_busy7_set_wins", EW'(busy_mask[7]), EW'(1));
    push_exp(5'd7, 64'h78);
    drive_mem(1'b1, 5'd7, 64'h78);
    tick();
    drive_mem(1'b0, '0, '0);
    tick();
    check("t5_busy7_cleared", EW'(busy_mask), EW'(0));

    // 6: halt with one buffered ALU result and busy[9] set.
    push_exp(5'd8, 64'h88);
    push_exp(5'd9, 64'h99);
    issue_valid = 1'b1; issue_rd = 5'd9;
    drive_mem(1'b1, 5'd8, 64'h88);
    drive_alu(1'b1, 5'd9, 64'h99);
    tick();
    issue_valid = 1'b0;
    drive_mem(1'b0, '0, '0);
    drive_alu(1'b0, '0, '0);
    halt_req = 1'b1;
    check("t6_busy9_set", EW'(busy_mask[9]), EW'(1));
    tick();
    halt_req = 1'b0;
    check("t6_drain_ready", EW'({alu_ready, mem_ready}), EW'(2'b01));
    check("t6_entry_written", EW'({wr_enable, rd_regno}), EW'({1'b1, 5'd9}));
    check("t6_no_dump_yet", EW'({display_regs, halted}), EW'(2'b00));
    tick();
    check("t6_busy_clear", EW'(busy_mask), EW'(0));
    check("t6_no_dump_while_busy", EW'(display_regs), EW'(0));
    tick();
    check("t6_dump_pulse", EW'({display_regs, halted}), EW'(2'b10));
    drive_mem(1'b1, 5'd1, 64'h11);
    tick();
    check("t6_halted", EW'({display_regs, halted}), EW'(2'b01));
    check("t6_ready_off", EW'({alu_ready, mem_ready}), EW'(2'b00));
    tick();
    drive_mem(1'b0, '0, '0);
    check("t6_stays_done", EW'({display_regs, halted, wr_enable}), EW'(3'b010));

    // Reset leaves DONE and issues no write afterwards.
    issue_valid = 1'b1; issue_rd = 5'd12;
    tick();
    issue_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst2_state", EW'({alu_ready, mem_ready, halted}), EW'(3'b110));
    check("rst2_busy", EW'(busy_mask), EW'(0));
    tick();
    check("rst2_no_wr", EW'(wr_enable), EW'(0));
    check("final_queue_empty", EW'(exp_q.size()), EW'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
